// File: rtl/fft32_pkg.sv
// Shared constants, stage-state encoding and helpers for the 32-point SDF FFT
// pipeline sequencer.
package fft32_pkg;

  localparam int NUM_STAGES = 5;
  localparam int LATENCY    = 36;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_BFLY = 2'd2,
    ST_TWID = 2'd3
  } stage_state_e;

  // Element k is stage k: delay-line length and live-tap offset of the stage input.
  localparam logic [NUM_STAGES-1:0][5:0] STAGE_D   = {6'd1, 6'd2, 6'd4, 6'd8, 6'd16};
  localparam logic [NUM_STAGES-1:0][5:0] STAGE_OFF = {6'd34, 6'd31, 6'd26, 6'd17, 6'd0};

  function automatic logic [4:0] bitrev5(input logic [4:0] v);
    return {v[0], v[1], v[2], v[3], v[4]};
  endfunction

endpackage

// File: rtl/fft32_stage_sched.sv
// Mode and twiddle-index decode for one SDF stage, derived from the global frame
// position and the live taps at the stage input and at the end of its delay line.
module fft32_stage_sched
  import fft32_pkg::*;
#(
  parameter int K = 0
) (
  input  logic [4:0] i_p0,
  input  logic       i_live_in,
  input  logic       i_live_del,
  output logic [1:0] o_state,
  output logic [3:0] o_tw_idx
);

  localparam logic [4:0] OFF = 5'(STAGE_OFF[K]);

  logic [4:0]   w_pk;
  logic [4:0]   w_rot;
  stage_state_e w_state;

  assign w_pk = i_p0 - OFF;
  // Shifting the local position left by K puts the butterfly-half bit at bit 4 and
  // leaves (p_k mod D_k) << K in the low nibble.
  assign w_rot = w_pk << K;

  always_comb begin
    w_state = ST_IDLE;
    if (w_rot[4] && i_live_in) begin
      w_state = ST_BFLY;
    end else if (!w_rot[4] && i_live_del) begin
      w_state = ST_TWID;
    end else if (!w_rot[4] && i_live_in) begin
      w_state = ST_FILL;
    end
  end

  assign o_state  = w_state;
  assign o_tw_idx = (w_state == ST_TWID) ? w_rot[3:0] : 4'd0;

endmodule

// File: rtl/fft32_sdf_sequencer.sv
// Frame-aligned controller for the 32-point radix-2 SDF FFT: input handshake,
// zero-pad auto-completion, global advance, per-stage scheduling and output tagging.
module fft32_sdf_sequencer
  import fft32_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        adv,
  output logic        pad,
  output logic [9:0]  stage_state,
  output logic [19:0] tw_idx,
  output logic        out_valid,
  output logic [4:0]  out_idx,
  output logic        busy
);

  logic [4:0]         r_p0;
  logic               r_frame_open;
  logic [LATENCY:1]   r_live;

  logic               w_accept;
  logic               w_new_live;
  logic [LATENCY-1:0] w_live;

  assign in_ready   = r_frame_open || (r_p0 == 5'd0);
  assign w_accept   = in_valid && in_ready;
  assign pad        = r_frame_open && !in_valid;
  assign w_new_live = w_accept || pad;
  assign adv        = w_new_live || (|r_live);

  // Tap t is the sample fed t advances ago; tap 0 is the one entering now.
  assign w_live = {r_live[LATENCY-1:1], w_new_live};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_p0         <= 5'd0;
      r_frame_open <= 1'b0;
      r_live       <= '0;
    end else if (adv) begin
      r_p0   <= r_p0 + 5'd1;
      r_live <= w_live;
      if (r_p0 == 5'd31) begin
        r_frame_open <= 1'b0;
      end else if (w_accept && (r_p0 == 5'd0)) begin
        r_frame_open <= 1'b1;
      end
    end else begin
      // Pipeline fully drained: park at frame position 0 so the next frame can start.
      r_p0 <= 5'd0;
    end
  end

  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
    fft32_stage_sched #(
      .K(gi)
    ) u_sched (
      .i_p0      (r_p0),
      .i_live_in (w_live[STAGE_OFF[gi]]),
      .i_live_del(w_live[STAGE_OFF[gi] + STAGE_D[gi]]),
      .o_state   (stage_state[2*gi +: 2]),
      .o_tw_idx  (tw_idx[4*gi +: 4])
    );
  end

  assign out_valid = r_live[LATENCY];
  assign out_idx   = r_live[LATENCY] ? bitrev5(r_p0 - 5'(LATENCY)) : 5'd0;
  assign busy      = r_frame_open || (|r_live);

endmodule

// File: tb/tb_fft32_sdf_sequencer.sv
// Scoreboard bench for fft32_sdf_sequencer: a frame-level reference model predicts
// every control output per cycle and queues the tag/arrival advance of each fed sample.
module tb_fft32_sdf_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        adv;
  logic        pad;
  logic [9:0]  stage_state;
  logic [19:0] tw_idx;
  logic        out_valid;
  logic [4:0]  out_idx;
  logic        busy;

  fft32_sdf_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .adv        (adv),
    .pad        (pad),
    .stage_state(stage_state),
    .tw_idx     (tw_idx),
    .out_valid  (out_valid),
    .out_idx    (out_idx),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [4:0] idx;
  } exp_t;

  exp_t sb[$];
  bit   hist[$];          // hist[i] = sample fed i+1 advances ago
  int   g_adv    = 0;     // advances since time zero
  int   m_cnt    = 0;     // advances since the pipeline was last idle
  int   m_fstart = -1;    // advance number at which the open frame began
  int   n_tests  = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] ref_bitrev(input int v);
    logic [4:0] r;
    for (int i = 0; i < 5; i++) r[i] = v[4-i];
    return r;
  endfunction

  // Reference model: per-cycle expectations at the falling edge, state update at the rising edge.
  initial begin : model
    int p, pk, d, off, b, st, tw;
    bit open, e_ready, acc, e_pad, nl, e_adv, e_busy, was_reset;
    bit lv[37];
    logic [9:0]  e_ss;
    logic [19:0] e_tw;
    exp_t e;
    forever begin
      @(negedge clk);
      was_reset = (reset === 1'b1);
      if (was_reset) begin
        hist.delete();
        sb.delete();
        m_cnt    = 0;
        m_fstart = -1;
      end
      p       = m_cnt % 32;
      open    = (m_fstart >= 0);
      e_ready = open || (p == 0);
      acc     = (in_valid === 1'b1) && e_ready;
      e_pad   = open && (in_valid !== 1'b1);
      nl      = acc || e_pad;
      lv[0]   = nl;
      e_adv   = nl;
      e_busy  = open;
      for (int t = 1; t <= 36; t++) begin
        lv[t]  = (t - 1 < hist.size()) ? hist[t-1] : 1'b0;
        e_adv  = e_adv | lv[t];
        e_busy = e_busy | lv[t];
      end
      e_ss = '0;
      e_tw = '0;
      off  = 0;
      for (int k = 0; k < 5; k++) begin
        d  = 16 >> k;
        pk = (p - off + 64) % 32;
        b  = (pk >> (4 - k)) & 1;
        if (b == 1 && lv[off])         st = 2;
        else if (b == 0 && lv[off+d])  st = 3;
        else if (b == 0 && lv[off])    st = 1;
        else                           st = 0;
        tw = (st == 3) ? (((pk % d) << k) & 15) : 0;
        e_ss[2*k +: 2] = 2'(st);
        e_tw[4*k +: 4] = 4'(tw);
        off = off + d + 1;
      end
      chk("in_ready",    32'(in_ready),    32'(e_ready));
      chk("pad",         32'(pad),         32'(e_pad));
      chk("adv",         32'(adv),         32'(e_adv));
      chk("stage_state", 32'(stage_state), 32'(e_ss));
      chk("tw_idx",      32'(tw_idx),      32'(e_tw));
      chk("out_valid",   32'(out_valid),   32'(lv[36]));
      chk("busy",        32'(busy),        32'(e_busy));
      @(posedge clk);
      if (!was_reset) begin
        if (e_adv) begin
          if (nl) begin
            e.due = g_adv + 36;
            e.idx = ref_bitrev(p);
            sb.push_back(e);
          end
          hist.push_front(nl);
          if (hist.size() > 36) void'(hist.pop_back());
          if (acc && p == 0) m_fstart = g_adv;
          else if (open && (g_adv - m_fstart == 31)) m_fstart = -1;
          m_cnt++;
          g_adv++;
        end else begin
          m_cnt = 0;
        end
      end
    end
  end

  // Output monitor: each emitted sample must match the oldest queued expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_extra_out: got out_valid with out_idx=%0d, expected no output (t=%0t)",
                   out_idx, $time);
        end else begin
          e = sb.pop_front();
          chk("out_idx",     32'(out_idx), 32'(e.idx));
          chk("out_arrival", 32'(g_adv),   32'(e.due));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic drive_frame(input int gap_lo, input int gap_hi);
    for (int i = 0; i < 32; i++) begin
      in_valid = !(i >= gap_lo && i <= gap_hi);
      tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin : driver
    int cnt;
    int lat;
    bit found;
    reset    = 1'b1;
    in_valid = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    idle(6);

    drive_frame(-1, -1);
    idle(45);

    repeat (64) begin
      in_valid = 1'b1;
      tick();
    end
    idle(45);

    drive_frame(10, 12);
    idle(45);

    // Late arrival after a frame closes is held off until the position wraps.
    drive_frame(-1, -1);
    idle(5);
    in_valid = 1'b1;
    cnt   = 0;
    found = 1'b0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        found = 1'b1;
        break;
      end
      cnt++;
      tick();
    end
    chk("holdoff_found",  32'(found), 32'd1);
    chk("holdoff_cycles", 32'(cnt),   32'd27);
    repeat (32) tick();
    idle(45);

    // Reset at position 20 of a second frame while the first is still emerging.
    repeat (52) begin
      in_valid = 1'b1;
      tick();
    end
    reset    = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("rst_outputs_zero", {adv, pad, stage_state, tw_idx, out_valid, out_idx, busy}, 32'd0);
    chk("rst_in_ready",     32'(in_ready), 32'd1);
    tick();
    tick();
    reset    = 1'b0;
    in_valid = 1'b1;
    lat   = -1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        lat = n;
        break;
      end
      @(posedge clk);
      #1;
      if (n == 31) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    chk("post_reset_latency", 32'(lat), 32'd36);
    idle(45);

    for (int r = 0; r < 10; r++) begin
      int len;
      len = $urandom_range(20, 90);
      for (int i = 0; i < len; i++) begin
        in_valid = ($urandom_range(0, 3) != 0);
        tick();
      end
      in_valid = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end
      idle($urandom_range(0, 50));
    end
    idle(45);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
